// File: rtl/qcv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qcv_mem_arbiter
// Purpose  : Shares one pipelined memory port (req/gnt/rvalid) between the
//            instruction fetch side and the LSU data side. Data has priority;
//            the instruction side is forced through after STARVE_LIMIT
//            consecutive data grants. A small in-order ID FIFO remembers who
//            issued each accepted request, and each response is steered back
//            to that requester.
// Ports    : clk_i, rst_i (async, active high)
//            instr_*  : fetch request in, gnt/rvalid/rdata/err out
//            data_*   : LSU request in (we/be/addr/wdata), gnt/rvalid/rdata/err out
//            mem_*    : single external memory port
//            busy_o   : outstanding transactions or a request pending
//            spurious_o : response seen with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module qcv_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        busy_o,
    output logic        spurious_o
);

    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL   = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_STV_W-1:0] c_STARVE_MAX = c_STV_W'(STARVE_LIMIT);

    logic [c_PTR_W-1:0]         r_wptr;
    logic [c_PTR_W-1:0]         r_rptr;
    logic [c_CNT_W-1:0]         r_count;
    logic [c_STV_W-1:0]         r_starve_cnt;
    logic [MAX_OUTSTANDING-1:0] w_ids;

    logic w_full;
    logic w_starved;
    logic w_data_win;
    logic w_instr_win;
    logic w_accept;
    logic w_outstanding;
    logic w_pop;
    logic w_resp_id;

    // ------------------------------------------------------------------
    // Arbitration: full is taken from the registered count, so a response
    // arriving while full frees a slot only for the following cycle.
    // ------------------------------------------------------------------
    assign w_full        = (r_count == c_CNT_FULL);
    assign w_starved     = instr_req_i && (r_starve_cnt == c_STARVE_MAX);
    assign w_data_win    = !w_full && data_req_i && !w_starved;
    assign w_instr_win   = !w_full && instr_req_i && !w_data_win;
    assign w_accept      = mem_req_o && mem_gnt_i;
    assign w_outstanding = (r_count != '0);
    assign w_pop         = mem_rvalid_i && w_outstanding;
    assign w_resp_id     = w_ids[r_rptr];

    assign mem_req_o   = w_data_win || w_instr_win;
    assign mem_we_o    = w_data_win ? data_we_i    : 1'b0;
    assign mem_be_o    = w_data_win ? data_be_i    : 4'hF;
    assign mem_wdata_o = w_data_win ? data_wdata_i : 32'h0;
    assign mem_addr_o  = w_data_win  ? data_addr_i  :
                         w_instr_win ? instr_addr_i : 32'h0;

    assign instr_gnt_o = w_instr_win && mem_gnt_i;
    assign data_gnt_o  = w_data_win  && mem_gnt_i;

    // Response steering: ID 0 = instruction side, ID 1 = data side.
    assign instr_rvalid_o = w_pop && !w_resp_id;
    assign data_rvalid_o  = w_pop &&  w_resp_id;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = instr_rvalid_o && mem_err_i;
    assign data_err_o     = data_rvalid_o  && mem_err_i;

    assign busy_o     = w_outstanding || instr_req_i || data_req_i;
    assign spurious_o = mem_rvalid_i && !w_outstanding;

    // ------------------------------------------------------------------
    // ID FIFO storage, one flop per slot.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < MAX_OUTSTANDING; g++) begin : g_id_fifo
            logic r_id;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_id <= 1'b0;
                end else if (w_accept && (r_wptr == c_PTR_W'(g))) begin
                    r_id <= w_data_win;
                end
            end
            assign w_ids[g] = r_id;
        end
    endgenerate

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Counts data grants taken while the fetch side is waiting; any cycle
    // without a fetch request, or a fetch grant, restarts the window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
        end else if (!instr_req_i) begin
            r_starve_cnt <= '0;
        end else if (instr_gnt_o) begin
            r_starve_cnt <= '0;
        end else if (data_gnt_o && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qcv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qcv_mem_arbiter
// Purpose  : Self-checking bench for qcv_mem_arbiter: directed scenarios plus
//            a randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qcv_mem_arbiter;

    localparam int MAXO = 2;
    localparam int SL   = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        busy_o;
    logic        spurious_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qcv_mem_arbiter #(
        .MAX_OUTSTANDING(MAXO),
        .STARVE_LIMIT   (SL)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_gnt_o   (instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_err_o   (instr_err_o),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_err_i     (mem_err_i),
        .busy_o        (busy_o),
        .spurious_o    (spurious_o)
    );

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        mem_err_i    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
        end
        checks++;
        if (mem_be_o !== 4'hF || mem_addr_o !== 32'h0 || mem_we_o !== 1'b0 || mem_wdata_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem be=%h addr=%h we=%b wdata=%h exp be=f others 0",
                     mem_be_o, mem_addr_o, mem_we_o, mem_wdata_o);
        end
        checks++;
        if (busy_o !== 1'b0 || spurious_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_status busy=%b spurious=%b exp 0 0", busy_o, spurious_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        @(negedge clk);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h100;
        mem_gnt_i    = 1'b1;
        #1;
        checks++;
        if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0 || mem_req_o !== 1'b1 ||
            mem_addr_o !== 32'h100 || mem_we_o !== 1'b0) begin
            failures++;
            $display("FAIL fetch_grant igt=%b dgt=%b req=%b addr=%h we=%b exp 1 0 1 100 0",
                     instr_gnt_o, data_gnt_o, mem_req_o, mem_addr_o, mem_we_o);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h13;
        #1;
        checks++;
        if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h13 || data_rvalid_o !== 1'b0 ||
            instr_err_o !== 1'b0) begin
            failures++;
            $display("FAIL fetch_resp irv=%b rdata=%h drv=%b err=%b exp 1 13 0 0",
                     instr_rvalid_o, instr_rdata_o, data_rvalid_o, instr_err_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_contention();
        bit exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            instr_req_i  = 1'b1;
            instr_addr_i = 32'h100;
            data_req_i   = 1'b1;
            data_addr_i  = 32'h2000;
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = (i > 0);
            mem_rdata_i  = 32'(i);
            #1;
            checks++;
            if (data_gnt_o !== exp_d[i] || instr_gnt_o !== !exp_d[i] ||
                mem_addr_o !== (exp_d[i] ? 32'h2000 : 32'h100)) begin
                failures++;
                $display("FAIL contention_gnt cyc=%0d dgt=%b igt=%b addr=%h exp dgt=%b",
                         i, data_gnt_o, instr_gnt_o, mem_addr_o, exp_d[i]);
            end
            if (i > 0) begin
                checks++;
                if (data_rvalid_o !== exp_d[i-1] || instr_rvalid_o !== !exp_d[i-1]) begin
                    failures++;
                    $display("FAIL contention_resp cyc=%0d drv=%b irv=%b exp drv=%b",
                             i, data_rvalid_o, instr_rvalid_o, exp_d[i-1]);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        mem_rvalid_i = 1'b1;
        #1;
        checks++;
        if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL contention_drain irv=%b drv=%b exp 1 0", instr_rvalid_o, data_rvalid_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data_req_i  = 1'b1;
            data_addr_i = 32'h40 + 32'(4 * i);
            mem_gnt_i   = 1'b1;
            #1;
            checks++;
            if (data_gnt_o !== 1'b1) begin
                failures++;
                $display("FAIL full_fill cyc=%0d dgt=%b exp 1", i, data_gnt_o);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || data_gnt_o !== 1'b0 || instr_gnt_o !== 1'b0) begin
            failures++;
            $display("FAIL full_block req=%b dgt=%b igt=%b exp 0 0 0", mem_req_o, data_gnt_o, instr_gnt_o);
        end
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || data_gnt_o !== 1'b0 || data_rvalid_o !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_same req=%b dgt=%b drv=%b exp 0 0 1", mem_req_o, data_gnt_o, data_rvalid_o);
        end
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || data_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL full_resume req=%b dgt=%b exp 1 1", mem_req_o, data_gnt_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_push_pop();
        do_reset();
        @(negedge clk);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h100;
        mem_gnt_i    = 1'b1;
        #1;
        checks++;
        if (instr_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL pushpop_first igt=%b exp 1", instr_gnt_o);
        end
        @(negedge clk);
        instr_req_i  = 1'b0;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h300;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hAAAA5555;
        #1;
        checks++;
        if (data_gnt_o !== 1'b1 || instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0 ||
            instr_rdata_o !== 32'hAAAA5555) begin
            failures++;
            $display("FAIL pushpop_same dgt=%b irv=%b drv=%b rdata=%h exp 1 1 0 aaaa5555",
                     data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_rdata_o);
        end
        @(negedge clk);
        data_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rdata_i  = 32'h1234;
        mem_err_i    = 1'b1;
        #1;
        checks++;
        if (data_rvalid_o !== 1'b1 || instr_rvalid_o !== 1'b0 || data_rdata_o !== 32'h1234 ||
            data_err_o !== 1'b1 || spurious_o !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_second drv=%b irv=%b rdata=%h err=%b spur=%b exp 1 0 1234 1 0",
                     data_rvalid_o, instr_rvalid_o, data_rdata_o, data_err_o, spurious_o);
        end
        @(negedge clk);
        mem_err_i = 1'b0;
        #1;
        checks++;
        if (spurious_o !== 1'b1 || data_rvalid_o !== 1'b0 || instr_rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_empty spur=%b drv=%b irv=%b exp 1 0 0", spurious_o, data_rvalid_o, instr_rvalid_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_data_write();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_req_i   = 1'b1;
            data_we_i    = 1'b1;
            data_be_i    = 4'b0011;
            data_addr_i  = 32'h2000;
            data_wdata_i = 32'hDEADBEEF;
            mem_gnt_i    = (i == 3);
            #1;
            checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 ||
                mem_addr_o !== 32'h2000 || mem_wdata_o !== 32'hDEADBEEF || data_gnt_o !== (i == 3)) begin
                failures++;
                $display("FAIL write_hold cyc=%0d req=%b we=%b be=%h addr=%h wd=%h dgt=%b exp 1 1 3 2000 deadbeef %b",
                         i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, data_gnt_o, (i == 3));
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_spurious();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data_req_i = 1'b1;
            mem_gnt_i  = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_busy busy=%b exp 1", busy_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_async_busy busy=%b exp 0", busy_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        #1;
        checks++;
        if (spurious_o !== 1'b1 || instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_late_resp spur=%b irv=%b drv=%b busy=%b exp 1 0 0 0",
                     spurious_o, instr_rvalid_o, data_rvalid_o, busy_o);
        end
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (spurious_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_spur_pulse spur=%b exp 0", spurious_o);
        end
    endtask

    // Reference model: a queue of requester tags for accepted-but-unanswered
    // transactions and a count of data grants taken while fetch waited.
    task automatic test_random();
        bit          q[$];
        int          starve = 0;
        bit          ip = 0, dp = 0;
        logic [31:0] ia = 0, da = 0, dw = 0;
        logic        dwe = 0;
        logic [3:0]  dbe = 0;
        int          win;
        bit          full, starved, accept, pop, id;
        logic [71:0] exp_req, got_req;
        logic [4:0]  exp_rsp, got_rsp;
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1'b1;
                ia = $urandom;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp  = 1'b1;
                da  = $urandom;
                dw  = $urandom;
                dwe = 1'($urandom_range(0, 1));
                dbe = 4'($urandom_range(0, 15));
            end
            instr_req_i  = ip;
            instr_addr_i = ia;
            data_req_i   = dp;
            data_addr_i  = da;
            data_wdata_i = dw;
            data_we_i    = dwe;
            data_be_i    = dbe;
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = 1'($urandom_range(0, 1));
            mem_rdata_i  = $urandom;
            mem_err_i    = ($urandom_range(0, 7) == 0);
            #1;
            full    = (q.size() == MAXO);
            starved = ip && (starve == SL);
            win     = 0;
            if (!full) begin
                if (dp && !starved) win = 2;
                else if (ip)        win = 1;
            end
            accept = (win != 0) && mem_gnt_i;
            pop    = mem_rvalid_i && (q.size() > 0);
            id     = (q.size() > 0) ? q[0] : 1'b0;

            if (win == 2)      exp_req = {1'b1, 1'b0, mem_gnt_i, dwe, dbe, da, dw};
            else if (win == 1) exp_req = {1'b1, mem_gnt_i, 1'b0, 1'b0, 4'hF, ia, 32'h0};
            else               exp_req = {1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0};
            got_req = {mem_req_o, instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
            checks++;
            if (got_req !== exp_req) begin
                failures++;
                $display("FAIL rand_req cyc=%0d got=%h exp=%h", cyc, got_req, exp_req);
            end

            exp_rsp = {pop && !id, pop && id, mem_rvalid_i && (q.size() == 0),
                       (q.size() > 0) || ip || dp, pop && mem_err_i};
            got_rsp = {instr_rvalid_o, data_rvalid_o, spurious_o, busy_o, instr_err_o | data_err_o};
            checks++;
            if (got_rsp !== exp_rsp) begin
                failures++;
                $display("FAIL rand_rsp cyc=%0d got=%b exp=%b", cyc, got_rsp, exp_rsp);
            end
            if (pop) begin
                checks++;
                if ((id ? data_rdata_o : instr_rdata_o) !== mem_rdata_i) begin
                    failures++;
                    $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc,
                             (id ? data_rdata_o : instr_rdata_o), mem_rdata_i);
                end
            end

            if (pop) void'(q.pop_front());
            if (accept) q.push_back(win == 2);
            if (!ip)                        starve = 0;
            else if (accept && win == 1)    starve = 0;
            else if (accept && win == 2)    starve = (starve < SL) ? starve + 1 : SL;
            if (accept && win == 1) ip = 1'b0;
            if (accept && win == 2) dp = 1'b0;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        test_reset();
        test_single_fetch();
        test_contention();
        test_full_stall();
        test_push_pop();
        test_data_write();
        test_reset_spurious();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
